deca_input_debounce: RTL and testbench

Debounce and event-capture stage for the DECA board push-buttons and slide switches. Sits directly upstream of the system's key and switch PIO inputs. Synchronises the raw pin levels into the system clock domain and filters contact bounce. Drives the PIO inputs with clean levels, and adds single-cycle press, release, long-press and switch-change pulses for interrupt or event logic.

---
 rtl/deca_input_debounce.sv | 146 ++++++++++++++
 tb/tb_deca_input_debounce.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/deca_input_debounce.sv
// deca_input_debounce
// Two-flop synchronisers, per-channel debounce filters and event pulses for
// the DECA push-buttons (active-low) and slide switches. Keys and switches
// share one channel vector: keys occupy the low N_KEY bits, switches above.
// Key channels also carry a hold timer that emits one long-press pulse per
// press.

module deca_input_debounce #(
    parameter int N_KEY       = 2,
    parameter int N_SW        = 2,
    parameter int DB_CYCLES   = 500000,
    parameter int LONG_CYCLES = 50000000
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [N_KEY-1:0] key_n_raw,
    input  logic [N_SW-1:0]  sw_raw,
    output logic [N_KEY-1:0] key_db,
    output logic [N_SW-1:0]  sw_db,
    output logic [N_KEY-1:0] key_press,
    output logic [N_KEY-1:0] key_release,
    output logic [N_KEY-1:0] key_long,
    output logic [N_SW-1:0]  sw_change
);

    localparam int N_CH   = N_KEY + N_SW;
    localparam int DB_W   = $clog2(DB_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
    // Keys idle high (released), switches idle low.
    localparam logic [N_CH-1:0]   CH_INIT   = {{N_SW{1'b0}}, {N_KEY{1'b1}}};

    logic [N_CH-1:0]              raw_s;
    logic [N_CH-1:0]              sync1_r;
    logic [N_CH-1:0]              sync2_r;
    logic [N_CH-1:0]              db_r;
    logic [N_CH-1:0]              db_s;
    logic [N_CH-1:0]              ev_s;
    logic [N_CH-1:0][DB_W-1:0]    cnt_r;
    logic [N_CH-1:0][DB_W-1:0]    cnt_s;

    logic [N_KEY-1:0][HOLD_W-1:0] hold_r;
    logic [N_KEY-1:0][HOLD_W-1:0] hold_s;
    logic [N_KEY-1:0]             fired_r;
    logic [N_KEY-1:0]             fired_s;
    logic [N_KEY-1:0]             long_r;
    logic [N_KEY-1:0]             long_s;
    logic [N_KEY-1:0]             press_r;
    logic [N_KEY-1:0]             press_s;
    logic [N_KEY-1:0]             release_r;
    logic [N_KEY-1:0]             release_s;
    logic [N_SW-1:0]              sw_chg_r;

    assign raw_s = {sw_raw, key_n_raw};

    // Two-flop synchroniser for every asynchronous pin.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sync1_r <= CH_INIT;
            sync2_r <= CH_INIT;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Debounce filter: the level only moves after DB_CYCLES consecutive mismatches.
    always_comb begin
        db_s  = db_r;
        cnt_s = cnt_r;
        ev_s  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sync2_r[i] == db_r[i]) begin
                cnt_s[i] = '0;
            end else if (cnt_r[i] == DB_LAST) begin
                cnt_s[i] = '0;
                db_s[i]  = sync2_r[i];
                ev_s[i]  = 1'b1;
            end else begin
                cnt_s[i] = cnt_r[i] + DB_W'(1);
            end
        end
    end

    // Split key events by direction of the new level (0 = pressed).
    always_comb begin
        press_s   = ev_s[N_KEY-1:0] & ~db_s[N_KEY-1:0];
        release_s = ev_s[N_KEY-1:0] &  db_s[N_KEY-1:0];
    end

    // Hold timer: counts cycles pressed, fires once, rearms on release.
    always_comb begin
        hold_s  = hold_r;
        fired_s = fired_r;
        long_s  = '0;
        for (int i = 0; i < N_KEY; i++) begin
            if (db_r[i]) begin
                hold_s[i]  = '0;
                fired_s[i] = 1'b0;
            end else if (!fired_r[i]) begin
                hold_s[i] = hold_r[i] + HOLD_W'(1);
                if (hold_r[i] == LONG_LAST) begin
                    fired_s[i] = 1'b1;
                    long_s[i]  = 1'b1;
                end else begin
                    fired_s[i] = 1'b0;
                end
            end else begin
                hold_s[i] = hold_r[i];
            end
        end
    end

    // Filter state, hold timers and registered event pulses.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            db_r      <= CH_INIT;
            cnt_r     <= '0;
            hold_r    <= '0;
            fired_r   <= '0;
            long_r    <= '0;
            press_r   <= '0;
            release_r <= '0;
            sw_chg_r  <= '0;
        end else begin
            db_r      <= db_s;
            cnt_r     <= cnt_s;
            hold_r    <= hold_s;
            fired_r   <= fired_s;
            long_r    <= long_s;
            press_r   <= press_s;
            release_r <= release_s;
            sw_chg_r  <= ev_s[N_CH-1:N_KEY];
        end
    end

    assign key_db      = db_r[N_KEY-1:0];
    assign sw_db       = db_r[N_CH-1:N_KEY];
    assign key_press   = press_r;
    assign key_release = release_r;
    assign key_long    = long_r;
    assign sw_change   = sw_chg_r;

endmodule

// File: tb/tb_deca_input_debounce.sv
// Directed testbench for deca_input_debounce with DB_CYCLES=8, LONG_CYCLES=40.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.

module tb_deca_input_debounce;

    localparam int N_KEY = 2;
    localparam int N_SW  = 2;
    localparam int DB    = 8;
    localparam int LONG  = 40;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_KEY-1:0] key_n_raw;
    logic [N_SW-1:0]  sw_raw;
    logic [N_KEY-1:0] key_db;
    logic [N_SW-1:0]  sw_db;
    logic [N_KEY-1:0] key_press;
    logic [N_KEY-1:0] key_release;
    logic [N_KEY-1:0] key_long;
    logic [N_SW-1:0]  sw_change;

    int checks   = 0;
    int failures = 0;
    int c_press[2];
    int c_rel[2];
    int c_long[2];
    int c_swc[2];
    int bad;

    deca_input_debounce #(
        .N_KEY      (N_KEY),
        .N_SW       (N_SW),
        .DB_CYCLES  (DB),
        .LONG_CYCLES(LONG)
    ) dut (
        .clk_clk    (clk),
        .reset_reset(rst),
        .key_n_raw  (key_n_raw),
        .sw_raw     (sw_raw),
        .key_db     (key_db),
        .sw_db      (sw_db),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long),
        .sw_change  (sw_change)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 2; i++) begin
            c_press[i] = 0;
            c_rel[i]   = 0;
            c_long[i]  = 0;
            c_swc[i]   = 0;
        end
    endtask

    task automatic run_count(input int n);
        repeat (n) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if (key_press[i])   c_press[i]++;
                if (key_release[i]) c_rel[i]++;
                if (key_long[i])    c_long[i]++;
                if (sw_change[i])   c_swc[i]++;
            end
        end
    endtask

    initial begin
        clear_counts();
        // ---------------- reset with random pins ----------------
        rst       = 1'b1;
        key_n_raw = 2'($urandom);
        sw_raw    = 2'($urandom);
        repeat (3) step();
        chk("rst_key_db", key_db, 2'b11);
        chk("rst_sw_db", sw_db, 2'b00);
        chk("rst_pulses", {key_press, key_release, key_long, sw_change}, 8'h00);
        // switch 0 held high through reset: software must see it once
        key_n_raw = 2'b11;
        sw_raw    = 2'b01;
        step();
        rst = 1'b0;
        step();
        chk("rel_first_pulses", {key_press, key_release, key_long, sw_change}, 8'h00);
        chk("rel_first_key_db", key_db, 2'b11);
        chk("rel_first_sw_db", sw_db, 2'b00);
        clear_counts();
        run_count(14);
        chk("init_sw0_change", c_swc[0], 1);
        chk("init_sw1_change", c_swc[1], 0);
        chk("init_sw_db", sw_db, 2'b01);
        chk("init_no_press", c_press[0] + c_press[1], 0);
        sw_raw = 2'b00;
        clear_counts();
        run_count(12);
        chk("sw0_back_change", c_swc[0], 1);
        chk("sw0_back_db", sw_db, 2'b00);

        // ---------------- clean press of key 0 ----------------
        key_n_raw = 2'b10;
        repeat (DB) step();                 // observed after edge 7
        step();                             // after edge 8
        chk("press_e8_db", key_db, 2'b11);
        chk("press_e8_pulse", key_press, 2'b00);
        step();                             // after edge 9
        chk("press_e9_db", key_db, 2'b10);
        chk("press_e9_pulse", key_press, 2'b01);
        step();
        chk("press_e10_pulse", key_press, 2'b00);
        chk("press_e10_db", key_db, 2'b10);

        // ---------------- long press of key 0 ----------------
        repeat (38) step();                 // 39 cycles after the press pulse cycle
        chk("long_before", key_long, 2'b00);
        step();                             // 40 cycles after
        chk("long_fire", key_long, 2'b01);
        clear_counts();
        run_count(55);
        chk("long_once", c_long[0], 0);
        chk("long_held_db", key_db, 2'b10);
        key_n_raw = 2'b11;
        repeat (9) step();
        chk("release_e8_db", key_db, 2'b10);
        chk("release_e8_pulse", key_release, 2'b00);
        step();
        chk("release_e9_db", key_db, 2'b11);
        chk("release_e9_pulse", key_release, 2'b01);
        step();
        chk("release_e10_pulse", key_release, 2'b00);
        // short second press: no long pulse
        key_n_raw = 2'b10;
        clear_counts();
        run_count(10);
        chk("press2_count", c_press[0], 1);
        clear_counts();
        run_count(20);
        key_n_raw = 2'b11;
        run_count(15);
        chk("press2_no_long", c_long[0], 0);
        chk("press2_release", c_rel[0], 1);
        chk("press2_db", key_db, 2'b11);

        // ---------------- bounce on key 1: low 5 / high 2 ----------------
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            key_n_raw = {((i % 7) >= 5) ? 1'b1 : 1'b0, 1'b1};
            step();
            if (key_db !== 2'b11 || key_press !== 2'b00) bad++;
        end
        chk("bounce_stable", bad, 0);
        // final low began at iteration 56; fall expected 9 edges later
        repeat (5) step();
        chk("bounce_e8_db", key_db, 2'b11);
        step();
        chk("bounce_e9_db", key_db, 2'b01);
        chk("bounce_e9_press", key_press, 2'b10);
        step();
        chk("bounce_e10_press", key_press, 2'b00);
        key_n_raw = 2'b11;
        clear_counts();
        run_count(12);
        chk("bounce_release", c_rel[1], 1);
        chk("bounce_no_long", c_long[1], 0);

        // ---------------- switches together with a key press ----------------
        key_n_raw = 2'b10;
        sw_raw    = 2'b11;
        repeat (9) step();
        chk("sim_e8_sw_db", sw_db, 2'b00);
        chk("sim_e8_change", sw_change, 2'b00);
        step();
        chk("sim_e9_change", sw_change, 2'b11);
        chk("sim_e9_press", key_press, 2'b01);
        chk("sim_e9_sw_db", sw_db, 2'b11);
        step();
        chk("sim_e10_change", sw_change, 2'b00);
        // 7-cycle glitch on switch 0
        clear_counts();
        sw_raw = 2'b10;
        run_count(7);
        sw_raw = 2'b11;
        run_count(15);
        chk("glitch_sw0", c_swc[0], 0);
        chk("glitch_sw1", c_swc[1], 0);
        chk("glitch_sw_db", sw_db, 2'b11);
        chk("glitch_no_long", c_long[0], 0);
        key_n_raw = 2'b11;
        sw_raw    = 2'b00;
        clear_counts();
        run_count(12);
        chk("sim_back_rel", c_rel[0], 1);
        chk("sim_back_swc", c_swc[0] + c_swc[1], 2);
        chk("sim_back_long", c_long[0], 0);
        chk("sim_back_sw_db", sw_db, 2'b00);

        // ---------------- reset in the middle of a debounce ----------------
        key_n_raw = 2'b10;
        repeat (7) step();                  // counter is 5 mismatches in
        rst = 1'b1;
        bad = 0;
        repeat (3) begin
            step();
            if (key_db !== 2'b11 || key_press !== 2'b00) bad++;
        end
        chk("midrst_hold", bad, 0);
        rst = 1'b0;
        repeat (9) step();
        chk("midrst_e8_db", key_db, 2'b11);
        chk("midrst_e8_press", key_press, 2'b00);
        step();
        chk("midrst_e9_db", key_db, 2'b10);
        chk("midrst_e9_press", key_press, 2'b01);
        step();
        // asynchronous reset takes effect without a clock edge
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_key_db", key_db, 2'b11);
        step();
        rst = 1'b0;
        key_n_raw = 2'b11;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
